// File: rtl/perm_round_scheduler.sv
// perm_round_scheduler
// Sequences the sLiSCP-light permutation datapath. One call runs NUM_STEPS steps.
// Each step is ROUNDS_PER_STEP Simeck-box round cycles followed by one mixing cycle,
// and the call ends with a single DONE cycle. The scheduler can be stalled, and it
// holds at most one start request that arrives while a call is already running.
module perm_round_scheduler #(
  parameter int NUM_STEPS       = 18,
  parameter int ROUNDS_PER_STEP = 8,
  parameter int STEP_W          = 5,
  parameter int RND_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              en_round,
  output logic              en_mix,
  output logic [RND_W-1:0]  round_idx,
  output logic [STEP_W-1:0] step_idx,
  output logic              last_step,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_MIX   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(ROUNDS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);

  state_e              state_q, state_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic [STEP_W-1:0]   step_q,  step_d;
  logic                pending_q, pending_d;

  // State, counters and the one-deep start queue; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      state_q   <= state_d;
      round_q   <= round_d;
      step_q    <= step_d;
      pending_q <= pending_d;
    end
  end

  // Next-state and counter update; a stall freezes ROUND/MIX, while DONE ignores it.
  always_comb begin
    // NOTE: hold-by-default assignments first so no path leaves a signal unassigned (no latches).
    state_d   = state_q;
    round_d   = round_q;
    step_d    = step_q;
    pending_d = pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROUND;
          round_d = '0;
          step_d  = '0;
        end
      end

      S_ROUND: begin
        if (start) pending_d = 1'b1;
        if (!stall) begin
          if (round_q == LAST_ROUND) state_d = S_MIX;
          else                       round_d = round_q + 1'b1;
        end
      end

      S_MIX: begin
        if (start) pending_d = 1'b1;
        if (!stall) begin
          round_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = S_ROUND;
          end
        end
      end

      S_DONE: begin
        // A start seen in this very cycle counts as queued, so it launches back-to-back too.
        round_d   = '0;
        step_d    = '0;
        pending_d = 1'b0;
        state_d   = (pending_q || start) ? S_ROUND : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: registers only, apart from the enables, which are also gated by stall.
  always_comb begin
    busy      = (state_q != S_IDLE);
    en_round  = (state_q == S_ROUND) && !stall;
    en_mix    = (state_q == S_MIX)   && !stall;
    done      = (state_q == S_DONE);
    round_idx = round_q;
    step_idx  = step_q;
    last_step = (state_q != S_IDLE) && (step_q == LAST_STEP);
  end

endmodule

// File: tb/tb_perm_round_scheduler.sv
// Directed self-checking bench for perm_round_scheduler (default parameters).
// Timing convention: inputs change and outputs are sampled 1 ns after a rising edge.
// Cycle 1 is the cycle that follows the edge at which start is sampled.
module tb_perm_round_scheduler;

  localparam int CYC_LIMIT = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       busy, en_round, en_mix, last_step, done;
  logic [2:0] round_idx;
  logic [4:0] step_idx;

  int tests    = 0;
  int failures = 0;

  perm_round_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .en_round  (en_round),
    .en_mix    (en_mix),
    .round_idx (round_idx),
    .step_idx  (step_idx),
    .last_step (last_step),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start from IDLE; on return the bench is in cycle 1 of the call.
  task automatic launch(output int c);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    c = 1;
  endtask

  task automatic advance_to(inout int c, input int target);
    while (c < target) begin
      tick();
      c++;
    end
  endtask

  // Run until done is seen, accumulating enable counts; the cycle budget bounds the wait.
  task automatic wait_done(inout int c, inout int nr, inout int nm);
    while (!done && c < CYC_LIMIT) begin
      nr += int'(en_round);
      nm += int'(en_mix);
      tick();
      c++;
    end
  endtask

  initial begin
    int c, nr, nm, pat_err, seen;

    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    #12;
    check("rst_busy",  busy,      0);
    check("rst_en",    {en_round, en_mix}, 0);
    check("rst_done",  done,      0);
    check("rst_idx",   {step_idx, round_idx}, 0);
    rst = 1'b1;
    tick();

    // ---- 1: plain call, no stall ------------------------------------------------
    launch(c);
    nr = 0; nm = 0; pat_err = 0;
    while (!done && c < CYC_LIMIT) begin
      // Cycle c of the call: position (c-1)%9 within a step, 0..7 round, 8 mix.
      if (en_round !== (((c - 1) % 9) < 8))                       pat_err++;
      if (en_mix   !== (((c - 1) % 9) == 8))                      pat_err++;
      if (step_idx !== 5'((c - 1) / 9))                           pat_err++;
      if (round_idx !== 3'((((c - 1) % 9) < 8) ? ((c - 1) % 9) : 7)) pat_err++;
      if (busy !== 1'b1)                                          pat_err++;
      nr += int'(en_round);
      nm += int'(en_mix);
      tick();
      c++;
    end
    check("t1_pattern",   pat_err, 0);
    check("t1_done_cyc",  c,       163);
    check("t1_en_round",  nr,      144);
    check("t1_en_mix",    nm,      18);
    check("t1_done_busy", busy,    1);
    check("t1_last_step", last_step, 1);
    tick();
    check("t1_done_pulse", done,   0);
    check("t1_busy_after", busy,   0);

    // ---- 2: five stall cycles at step 3 round 4 -----------------------------------
    launch(c);
    nr = 0; nm = 0;
    while (c < 32) begin
      nr += int'(en_round);
      nm += int'(en_mix);
      tick();
      c++;
    end
    check("t2_pos", {step_idx, round_idx}, {5'd3, 3'd4});
    stall = 1'b1;
    #1;
    pat_err = 0;
    for (int i = 0; i < 5; i++) begin
      if (en_round !== 1'b0 || en_mix !== 1'b0)     pat_err++;
      if (step_idx !== 5'd3 || round_idx !== 3'd4)  pat_err++;
      tick();
      c++;
    end
    check("t2_frozen", pat_err, 0);
    stall = 1'b0;
    #1;
    check("t2_resume", {en_round, step_idx, round_idx}, {1'b1, 5'd3, 3'd4});
    wait_done(c, nr, nm);
    check("t2_done_cyc", c,  168);
    check("t2_en_round", nr, 144);
    check("t2_en_mix",   nm, 18);
    tick();
    check("t2_idle", busy, 0);

    // ---- 3: start held high from step 10 until the DONE cycle -------------------
    launch(c);
    advance_to(c, 91);
    check("t3_pos", step_idx, 10);
    start = 1'b1;
    nr = 0; nm = 0;
    wait_done(c, nr, nm);
    check("t3_done1_cyc", c, 163);
    tick();
    c = 1;
    start = 1'b0;
    #1;
    check("t3_b2b", {done, busy, en_round, step_idx, round_idx}, {1'b0, 1'b1, 1'b1, 5'd0, 3'd0});
    nr = 0; nm = 0;
    wait_done(c, nr, nm);
    check("t3_done2_cyc", c,  163);
    check("t3_en_round2", nr, 144);
    tick();
    check("t3_one_queued", busy, 0);

    // ---- 4: asynchronous reset at step 7 round 2 ---------------------------------
    launch(c);
    advance_to(c, 66);
    check("t4_pos", {step_idx, round_idx}, {5'd7, 3'd2});
    #2;
    rst = 1'b0;
    #1;
    check("t4_async", {busy, en_round, en_mix, done, last_step, step_idx, round_idx}, 0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("t4_no_done", seen, 0);
    launch(c);
    nr = 0; nm = 0;
    wait_done(c, nr, nm);
    check("t4_rerun_cyc", c,  163);
    check("t4_rerun_rnd", nr, 144);

    // ---- 5: stall and start in the DONE cycle ------------------------------------
    stall = 1'b1;
    start = 1'b1;
    #1;
    check("t5_done_stall", {done, en_round, en_mix}, {1'b1, 1'b0, 1'b0});
    tick();
    stall = 1'b0;
    start = 1'b0;
    #1;
    check("t5_one_cycle", {done, busy, en_round, step_idx, round_idx}, {1'b0, 1'b1, 1'b1, 5'd0, 3'd0});
    c = 1;
    nr = 0; nm = 0;
    wait_done(c, nr, nm);
    check("t5_queued_cyc", c, 163);
    tick();
    check("t5_idle", busy, 0);

    // ---- 6: idle with stall toggling ---------------------------------------------
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      stall = ~stall;
      #1;
      if (busy || en_round || en_mix || done) seen++;
      tick();
    end
    stall = 1'b0;
    check("t6_idle_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
